wb_arbiter: RTL and testbench

Write-back arbiter that owns the single register-file write port (`wbEn`/`wbDst`/`wbVal`). It merges in-order ALU results from the MEM/WB pipeline register with variable-latency load responses from the data-memory interface. Load responses are buffered in a small FIFO. A per-register pending-load scoreboard is exported to the hazard unit. Sits between the MEM stage / memory interface and the register file in the ID stage.

---
 rtl/arm_pkg.sv | 15 +
 rtl/wb_fifo.sv | 52 +++++
 rtl/wb_arbiter.sv | 160 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared core definitions: register-file geometry and the write-back request record.
package arm_pkg;

  localparam int REG_IDX_W = 4;
  localparam int DATA_W    = 32;
  localparam int PC_IDX    = 15;
  localparam int NUM_GPR   = 15;

  typedef struct packed {
    logic                 en;
    logic [REG_IDX_W-1:0] dst;
    logic [DATA_W-1:0]    val;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with combinational head read (one-cycle pop) and async active-high reset.
// A push when full or a pop when empty is ignored.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra wrap bit on each pointer distinguishes full from empty.
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Owns the register-file write port: merges ALU results with buffered load responses
// and tracks outstanding loads per register. Optional starvation guard: WB_STARVE_GUARD_EN.
module wb_arbiter
  import arm_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 exeWbEn,
  input  logic [REG_IDX_W-1:0] exeDst,
  input  logic [DATA_W-1:0]    exeVal,
  input  logic                 ldValid,
  input  logic [REG_IDX_W-1:0] ldDst,
  input  logic [DATA_W-1:0]    ldData,
  output logic                 ldReady,
  input  logic                 ldIssue,
  input  logic [REG_IDX_W-1:0] ldIssueDst,
  output logic [NUM_GPR-1:0]   pending,
  output logic                 pendErr,
  output logic                 stallReq,
  output logic                 wbEn,
  output logic [REG_IDX_W-1:0] wbDst,
  output logic [DATA_W-1:0]    wbVal
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wb_arbiter: DEPTH must be a power of two >= 2");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("wb_arbiter: STARVE_LIMIT must be >= 1");
  end

  wb_req_t    wb_q, wb_d;
  wb_req_t    ld_req, head;
  logic       fifo_full, fifo_empty, fifo_push;
  logic       pop, alu_win, alu_ok;
  logic       stall_q;
  logic [1:0] cnt_q [NUM_GPR];
  logic [1:0] cnt_d [NUM_GPR];
  logic       pend_err_q, pend_err_d;

  // Loads to the PC slot are carried through the FIFO with en cleared so their
  // pop is a silent write-back slot.
  assign ld_req    = '{en: (ldDst != REG_IDX_W'(PC_IDX)), dst: ldDst, val: ldData};
  assign ldReady   = !fifo_full;
  assign fifo_push = ldValid && ldReady;

  wb_fifo #(
    .WIDTH($bits(wb_req_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (fifo_push),
    .wdata_i(ld_req),
    .pop_i  (pop),
    .rdata_o(head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign alu_ok = exeWbEn && (exeDst != REG_IDX_W'(PC_IDX));

  always_comb begin
    pop     = 1'b0;
    alu_win = 1'b0;
    wb_d    = '0;
    if (stall_q && !fifo_empty) begin
      pop = 1'b1;
    end else if (alu_ok) begin
      alu_win = 1'b1;
    end else if (!fifo_empty) begin
      pop = 1'b1;
    end
    if (pop) begin
      wb_d = head;
    end else if (alu_win) begin
      wb_d = '{en: 1'b1, dst: exeDst, val: exeVal};
    end
  end

  // Pending-load counters: an issue and a retiring write on the same register cancel.
  always_comb begin
    pend_err_d = pend_err_q;
    for (int i = 0; i < NUM_GPR; i++) begin
      logic inc, dec;
      inc      = ldIssue && (ldIssueDst == REG_IDX_W'(i));
      dec      = pop && (head.dst == REG_IDX_W'(i));
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) begin
        if (cnt_q[i] == 2'd3) pend_err_d = 1'b1;
        else                  cnt_d[i]   = cnt_q[i] + 2'd1;
      end else if (dec && !inc && cnt_q[i] != 2'd0) begin
        cnt_d[i] = cnt_q[i] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q       <= '0;
      pend_err_q <= 1'b0;
      for (int i = 0; i < NUM_GPR; i++) cnt_q[i] <= 2'd0;
    end else begin
      wb_q       <= wb_d;
      pend_err_q <= pend_err_d;
      for (int i = 0; i < NUM_GPR; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          stall_d;

  // Counts cycles the ALU beat a waiting load; the cycle that would reach the
  // limit instead registers a one-cycle stall that hands the port to the FIFO.
  always_comb begin
    starve_d = starve_q;
    stall_d  = 1'b0;
    if (pop) begin
      starve_d = '0;
    end else if (alu_win && !fifo_empty) begin
      if (starve_q == SW'(STARVE_LIMIT - 1)) begin
        starve_d = '0;
        stall_d  = 1'b1;
      end else begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end
`else
  assign stall_q = 1'b0;
`endif

  always_comb begin
    pending = '0;
    for (int i = 0; i < NUM_GPR; i++) pending[i] = (cnt_q[i] != 2'd0);
  end

  assign pendErr  = pend_err_q;
  assign stallReq = stall_q;
  assign wbEn     = wb_q.en;
  assign wbDst    = wb_q.dst;
  assign wbVal    = wb_q.val;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        exeWbEn;
  logic [3:0]  exeDst;
  logic [31:0] exeVal;
  logic        ldValid;
  logic [3:0]  ldDst;
  logic [31:0] ldData;
  logic        ldReady;
  logic        ldIssue;
  logic [3:0]  ldIssueDst;
  logic [14:0] pending;
  logic        pendErr;
  logic        stallReq;
  logic        wbEn;
  logic [3:0]  wbDst;
  logic [31:0] wbVal;

  int n_vec = 0;
  int n_bad = 0;

  logic [35:0] exp_q[$];

  typedef struct {
    logic        exe_en;
    logic [3:0]  exe_dst;
    logic [31:0] exe_val;
    logic        ld_v;
    logic [3:0]  ld_dst;
    logic [31:0] ld_data;
    logic        iss;
    logic [3:0]  iss_dst;
    logic        e_en;
    logic [3:0]  e_dst;
    logic [31:0] e_val;
    logic        e_rdy;
    logic [14:0] e_pend;
  } vec_t;

  vec_t vt[12];

  wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .exeWbEn   (exeWbEn),
    .exeDst    (exeDst),
    .exeVal    (exeVal),
    .ldValid   (ldValid),
    .ldDst     (ldDst),
    .ldData    (ldData),
    .ldReady   (ldReady),
    .ldIssue   (ldIssue),
    .ldIssueDst(ldIssueDst),
    .pending   (pending),
    .pendErr   (pendErr),
    .stallReq  (stallReq),
    .wbEn      (wbEn),
    .wbDst     (wbDst),
    .wbVal     (wbVal)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic idle();
    exeWbEn = 0; exeDst = 0; exeVal = 0;
    ldValid = 0; ldDst = 0; ldData = 0;
    ldIssue = 0; ldIssueDst = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic alu(input logic [3:0] d, input logic [31:0] v);
    exeWbEn = 1; exeDst = d; exeVal = v;
  endtask

  task automatic load(input logic [3:0] d, input logic [31:0] v);
    ldValid = 1; ldDst = d; ldData = v;
  endtask

  // Scoreboard compare
  task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_wb(input string nm, input logic [3:0] d, input logic [31:0] v);
    check({nm, ".wbEn"}, 36'(wbEn), 36'd1);
    check({nm, ".wb"}, {wbDst, wbVal}, {d, v});
  endtask

  initial begin
    // en dst val | ld dst data | iss dst | exp en dst val rdy pend
    vt[0]  = '{1, 4'd5,  32'hDEADBEEF, 0, 4'd0,  32'h0,  0, 4'd0, 1, 4'd5,  32'hDEADBEEF, 1, 15'h0000};
    vt[1]  = '{1, 4'd15, 32'h00000123, 0, 4'd0,  32'h0,  0, 4'd0, 0, 4'd0,  32'h0,        1, 15'h0000};
    vt[2]  = '{1, 4'd4,  32'h00000022, 1, 4'd2,  32'h11, 0, 4'd0, 1, 4'd4,  32'h22,       1, 15'h0000};
    vt[3]  = '{0, 4'd0,  32'h0,        0, 4'd0,  32'h0,  0, 4'd0, 1, 4'd2,  32'h11,       1, 15'h0000};
    vt[4]  = '{0, 4'd0,  32'h0,        0, 4'd0,  32'h0,  0, 4'd0, 0, 4'd0,  32'h0,        1, 15'h0000};
    vt[5]  = '{0, 4'd0,  32'h0,        0, 4'd0,  32'h0,  1, 4'd3, 0, 4'd0,  32'h0,        1, 15'h0008};
    vt[6]  = '{0, 4'd0,  32'h0,        1, 4'd3,  32'h33, 0, 4'd0, 0, 4'd0,  32'h0,        1, 15'h0008};
    vt[7]  = '{0, 4'd0,  32'h0,        0, 4'd0,  32'h0,  0, 4'd0, 1, 4'd3,  32'h33,       1, 15'h0000};
    vt[8]  = '{0, 4'd0,  32'h0,        1, 4'd15, 32'h55, 0, 4'd0, 0, 4'd0,  32'h0,        1, 15'h0000};
    vt[9]  = '{1, 4'd6,  32'h00000066, 0, 4'd0,  32'h0,  0, 4'd0, 1, 4'd6,  32'h66,       1, 15'h0000};
    vt[10] = '{0, 4'd0,  32'h0,        0, 4'd0,  32'h0,  0, 4'd0, 0, 4'd0,  32'h0,        1, 15'h0000};
    vt[11] = '{1, 4'd0,  32'h00000000, 0, 4'd0,  32'h0,  0, 4'd0, 1, 4'd0,  32'h0,        1, 15'h0000};

    // Reset state
    do_reset();
    check("rst.wbEn", 36'(wbEn), 36'd0);
    check("rst.wb", {wbDst, wbVal}, 36'd0);
    check("rst.ldReady", 36'(ldReady), 36'd1);
    check("rst.pending", 36'(pending), 36'd0);
    check("rst.pendErr", 36'(pendErr), 36'd0);
    check("rst.stallReq", 36'(stallReq), 36'd0);

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      exeWbEn = vt[i].exe_en; exeDst = vt[i].exe_dst; exeVal = vt[i].exe_val;
      ldValid = vt[i].ld_v;   ldDst = vt[i].ld_dst;   ldData = vt[i].ld_data;
      ldIssue = vt[i].iss;    ldIssueDst = vt[i].iss_dst;
      step();
      check($sformatf("vec%0d.wbEn", i), 36'(wbEn), 36'(vt[i].e_en));
      if (vt[i].e_en)
        check($sformatf("vec%0d.wb", i), {wbDst, wbVal}, {vt[i].e_dst, vt[i].e_val});
      check($sformatf("vec%0d.ldReady", i), 36'(ldReady), 36'(vt[i].e_rdy));
      check($sformatf("vec%0d.pending", i), 36'(pending), 36'(vt[i].e_pend));
      check($sformatf("vec%0d.stallReq", i), 36'(stallReq), 36'd0);
    end
    idle();

    // Backpressure: four loads fill the FIFO behind continuous ALU writes
    do_reset();
    for (int k = 0; k < 4; k++) begin
      alu(4'd1, 32'h100 + k);
      load(4'(8 + k), 32'hA0 + k);
      exp_q.push_back({4'(8 + k), 32'hA0 + k});
      step();
    end
    check("bp.full_ldReady", 36'(ldReady), 36'd0);
    alu(4'd1, 32'h104);
    load(4'd12, 32'hA4);
    exp_q.push_back({4'd12, 32'hA4});
    step();
    check("bp.held_ldReady", 36'(ldReady), 36'd0);
    check_wb("bp.alu_wins", 4'd1, 32'h104);
    exeWbEn = 0;
    for (int c = 0; c < 12; c++) begin
      logic acc;
      acc = ldValid && ldReady;
      step();
      if (acc) ldValid = 0;
      if (wbEn) begin
        if (exp_q.size() == 0) check("bp.extra_wb", {wbDst, wbVal}, 36'd0);
        else check("bp.order", {wbDst, wbVal}, exp_q.pop_front());
      end
    end
    check("bp.drained", 36'(exp_q.size()), 36'd0);
    check("bp.pending_idle", 36'(pending), 36'd0);
    idle();

    // Scoreboard: saturation, same-edge issue/retire, drain
    do_reset();
    ldIssue = 1; ldIssueDst = 4'd7;
    step(); step(); step();
    ldIssue = 0;
    check("sb.pend7_after3", 36'(pending[7]), 36'd1);
    check("sb.err_after3", 36'(pendErr), 36'd0);
    load(4'd7, 32'h70);
    step();
    ldValid = 0;
    ldIssue = 1; ldIssueDst = 4'd7;
    step();
    ldIssue = 0;
    check_wb("sb.same_edge_wb", 4'd7, 32'h70);
    check("sb.same_edge_err", 36'(pendErr), 36'd0);
    ldIssue = 1; ldIssueDst = 4'd7;
    step();
    ldIssue = 0;
    check("sb.sat_err", 36'(pendErr), 36'd1);
    for (int k = 0; k < 3; k++) begin
      load(4'd7, 32'h71 + k);
      step();
      ldValid = 0;
      step();
      check_wb($sformatf("sb.retire%0d", k), 4'd7, 32'h71 + k);
      check($sformatf("sb.pend7_retire%0d", k), 36'(pending), (k < 2) ? 36'h80 : 36'h0);
    end
    check("sb.err_sticky", 36'(pendErr), 36'd1);
    idle();

    // Reset mid-operation: two buffered loads and a pending register
    do_reset();
    alu(4'd1, 32'h1); load(4'd4, 32'h44); ldIssue = 1; ldIssueDst = 4'd3;
    step();
    ldIssue = 0;
    alu(4'd1, 32'h2); load(4'd5, 32'h55);
    step();
    idle();
    check("mid.pre_pending", 36'(pending), 36'h8);
    check_wb("mid.pre_wb", 4'd1, 32'h2);
    rst = 1;
    #2;
    check("mid.async_wbEn", 36'(wbEn), 36'd0);
    check("mid.async_pending", 36'(pending), 36'd0);
    check("mid.async_ldReady", 36'(ldReady), 36'd1);
    rst = 0;
    step();
    check("mid.fifo_discard0", 36'(wbEn), 36'd0);
    step();
    check("mid.fifo_discard1", 36'(wbEn), 36'd0);

`ifdef WB_STARVE_GUARD_EN
    // Starvation guard: one buffered load behind eight ALU wins
    do_reset();
    alu(4'd1, 32'h100); load(4'd9, 32'h99);
    step();
    ldValid = 0;
    for (int k = 1; k <= 8; k++) begin
      alu(4'd1, 32'h100 + k);
      step();
      if (k == 7) check("sg.no_stall_early", 36'(stallReq), 36'd0);
    end
    check("sg.stall_set", 36'(stallReq), 36'd1);
    check_wb("sg.last_alu", 4'd1, 32'h108);
    alu(4'd2, 32'h200);
    step();
    check_wb("sg.load_wins", 4'd9, 32'h99);
    check("sg.stall_one_cycle", 36'(stallReq), 36'd0);
    step();
    check_wb("sg.held_alu", 4'd2, 32'h200);
    check("sg.stall_clear", 36'(stallReq), 36'd0);
    idle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
